// File: rtl/ddr3_arbiter_pkg.sv
// Shared types and constants for the DDR3 access-port arbiter.
package ddr3_arbiter_pkg;

    localparam int DDR3_ADDR_W = 28;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } ddr3_arb_state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr3_arbiter_pick.sv
// Combinational winner selector: first set request at or after i_start, wrapping.
// Used with i_start = 0 for fixed priority and last_owner+1 for round-robin.
module ddr3_arb_pick
    import ddr3_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    // NOTE: blocking assignments inside always_comb evaluate in order; scanning
    // from the farthest offset down lets the nearest requester overwrite last and win.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_cand   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = IDX_W'((int'(i_start) + k) % N);
            if (i_req[w_cand]) begin
                o_onehot         = '0;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/ddr3_arbiter.sv
// Registered-grant arbiter sharing one DDR3 access port among NUM_REQ requesters.
// Define DDR3_ARB_RR_EN for round-robin winner selection; default is fixed priority.
module ddr3_arbiter
    import ddr3_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = DDR3_ADDR_W,
    parameter int MAX_HOLD = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0]        i_req_rd,
    input  logic [NUM_REQ-1:0]        i_req_wr,
    input  logic [NUM_REQ*8-1:0]      i_req_din,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [ADDR_W-1:0]         o_ddr3_addr,
    output logic                      o_ddr3_rd,
    output logic                      o_ddr3_wr,
    output logic [7:0]                o_ddr3_din,
    input  logic                      i_ddr3_ready,
    output logic                      o_ddr3_request
);

    localparam int                IDX_W    = idx_width(NUM_REQ);
    localparam int                HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD > 1) ? HOLD_W'(MAX_HOLD - 1) : '0;

    ddr3_arb_state_t    r_state,    w_state_nxt;
    logic [NUM_REQ-1:0] r_grant,    w_grant_nxt;
    logic [IDX_W-1:0]   r_owner,    w_owner_nxt;
    logic [HOLD_W-1:0]  r_hold_cnt, w_hold_nxt;
    logic               r_pending,  w_pending_nxt;
    logic               r_seen_low, w_seen_low_nxt;

    logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];
    logic [7:0]         w_din_arr  [NUM_REQ];
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [NUM_REQ-1:0] w_pick_onehot;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_own;
    logic               w_fwd_rd;
    logic               w_fwd_wr;
    logic               w_own_req;
    logic               w_other_req;
    logic               w_hold_hit;
    logic               w_release;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_addr_arr[gi] = i_req_addr[gi*ADDR_W +: ADDR_W];
        assign w_din_arr[gi]  = i_req_din[gi*8 +: 8];
    end

    // r_owner keeps the last granted index after release, so it doubles as last_owner.
`ifdef DDR3_ARB_RR_EN
    assign w_start = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
`else
    assign w_start = '0;
`endif

    ddr3_arb_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (i_req),
        .i_start  (w_start),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_own       = (r_state == OWN);
    assign w_ready     = r_grant & {NUM_REQ{i_ddr3_ready & ~r_pending}};
    assign w_fwd_rd    = i_req_rd[r_owner] & w_ready[r_owner];
    assign w_fwd_wr    = i_req_wr[r_owner] & w_ready[r_owner] & ~i_req_rd[r_owner];
    assign w_own_req   = |(i_req & r_grant);
    assign w_other_req = |(i_req & ~r_grant);
    assign w_hold_hit  = (MAX_HOLD != 0) && (r_hold_cnt >= HOLD_SAT);
    assign w_release   = ~r_pending & (~w_own_req | (w_hold_hit & w_other_req));

    assign o_req_ready    = w_ready;
    assign o_grant        = r_grant;
    assign o_ddr3_rd      = w_fwd_rd;
    assign o_ddr3_wr      = w_fwd_wr;
    assign o_ddr3_addr    = w_own ? w_addr_arr[r_owner] : '0;
    assign o_ddr3_din     = w_own ? w_din_arr[r_owner]  : '0;
    assign o_ddr3_request = |r_grant;

    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_owner_nxt    = r_owner;
        w_hold_nxt     = r_hold_cnt;
        w_pending_nxt  = r_pending;
        w_seen_low_nxt = r_seen_low;

        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = OWN;
                    w_grant_nxt = w_pick_onehot;
                    w_owner_nxt = w_pick_idx;
                    w_hold_nxt  = '0;
                end
            end
            OWN: begin
                if (r_hold_cnt < HOLD_SAT) begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase

        // A command completes once ready has been low and then comes back high.
        if (w_fwd_rd || w_fwd_wr) begin
            w_pending_nxt  = 1'b1;
            w_seen_low_nxt = 1'b0;
        end else if (r_pending) begin
            if (!i_ddr3_ready) begin
                w_seen_low_nxt = 1'b1;
            end else if (r_seen_low) begin
                w_pending_nxt  = 1'b0;
                w_seen_low_nxt = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= IDX_W'(NUM_REQ - 1);
            r_hold_cnt <= '0;
            r_pending  <= 1'b0;
            r_seen_low <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_pending  <= w_pending_nxt;
            r_seen_low <= w_seen_low_nxt;
        end
    end

endmodule

// File: tb/tb_ddr3_arbiter.sv
// Randomized scoreboard bench for ddr3_arbiter against a cycle-level reference model.
module tb_ddr3_arbiter;

    localparam int N        = 4;
    localparam int AW       = 28;
    localparam int MAX_HOLD = 8;
    localparam int CYCLES   = 3000;
`ifdef DDR3_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [N-1:0]  ready;
        logic          request;
        logic          strobe;
        logic [AW-1:0] addr;
        logic [7:0]    din;
    } status_t;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    din;
    } cmd_t;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_rd;
    logic [N-1:0]    req_wr;
    logic [N*8-1:0]  req_din;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    grant;
    logic [AW-1:0]   ddr3_addr;
    logic            ddr3_rd;
    logic            ddr3_wr;
    logic [7:0]      ddr3_din;
    logic            ddr3_ready;
    logic            ddr3_request;

    status_t status_q[$];
    cmd_t    cmd_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_now  = 0;

    // Reference model state
    int m_owner;
    int m_last;
    bit m_pending;
    bit m_seen;
    int m_hold;
    bit m_fwd;

    int busy;
    int burst_left [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ddr3_arbiter #(
        .NUM_REQ  (N),
        .ADDR_W   (AW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req          (req),
        .i_req_addr     (req_addr),
        .i_req_rd       (req_rd),
        .i_req_wr       (req_wr),
        .i_req_din      (req_din),
        .o_req_ready    (req_ready),
        .o_grant        (grant),
        .o_ddr3_addr    (ddr3_addr),
        .o_ddr3_rd      (ddr3_rd),
        .o_ddr3_wr      (ddr3_wr),
        .o_ddr3_din     (ddr3_din),
        .i_ddr3_ready   (ddr3_ready),
        .o_ddr3_request (ddr3_request)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_now, act, exp);
        end
    endtask

    function automatic int pick_winner(input logic [N-1:0] r, input int last);
        int start;
        start = RR_MODE ? (last + 1) % N : 0;
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_cycle(input int cyc);
        int phase;
        phase      = (cyc < 1500) ? 0 : ((cyc < 2200) ? 1 : 2);
        reset      = (cyc < 2) || ($urandom_range(0, 299) == 0);
        ddr3_ready = (busy == 0) && ($urandom_range(0, 15) != 0);
        for (int i = 0; i < N; i++) begin
            if (reset) burst_left[i] = 0;
            if (phase == 1) begin
                req[i] = 1'b1;
            end else if (burst_left[i] > 0) begin
                req[i] = 1'b1;
                burst_left[i]--;
            end else begin
                req[i] = 1'b0;
                if ($urandom_range(0, (phase == 2) ? 30 : 6) == 0)
                    burst_left[i] = $urandom_range(1, 20);
            end
            req_rd[i]             = ($urandom_range(0, 3) == 0);
            req_wr[i]             = ($urandom_range(0, 3) == 0);
            req_addr[i*AW +: AW]  = AW'($urandom());
            req_din[i*8 +: 8]     = 8'($urandom());
        end
    endtask

    // Expected outputs for this cycle, then the model's next state.
    task automatic model_cycle();
        status_t s;
        cmd_t    c;
        logic [N-1:0] others;
        bit fwd_rd, fwd_wr, rel;
        int w;

        s = '0;
        if (m_owner >= 0) begin
            s.grant[m_owner] = 1'b1;
            s.request        = 1'b1;
            s.addr           = req_addr[m_owner*AW +: AW];
            s.din            = req_din[m_owner*8 +: 8];
            if (ddr3_ready && !m_pending) s.ready[m_owner] = 1'b1;
        end
        fwd_rd = 1'b0;
        fwd_wr = 1'b0;
        if (s.ready != '0) begin
            fwd_rd = req_rd[m_owner];
            fwd_wr = req_wr[m_owner] && !req_rd[m_owner];
        end
        m_fwd    = fwd_rd || fwd_wr;
        s.strobe = m_fwd;
        status_q.push_back(s);
        if (m_fwd) begin
            c.rd   = fwd_rd;
            c.wr   = fwd_wr;
            c.addr = s.addr;
            c.din  = s.din;
            cmd_q.push_back(c);
        end

        if (reset) begin
            m_owner   = -1;
            m_last    = N - 1;
            m_pending = 1'b0;
            m_seen    = 1'b0;
            m_hold    = 0;
        end else begin
            if (m_owner < 0) begin
                w = pick_winner(req, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_last  = w;
                    m_hold  = 0;
                end
            end else begin
                others          = req;
                others[m_owner] = 1'b0;
                rel = !m_pending &&
                      (!req[m_owner] || (m_hold >= MAX_HOLD - 1 && others != '0));
                if (m_hold < MAX_HOLD - 1) m_hold++;
                if (rel) m_owner = -1;
            end
            if (m_fwd) begin
                m_pending = 1'b1;
                m_seen    = 1'b0;
            end else if (m_pending) begin
                if (!ddr3_ready) m_seen = 1'b1;
                else if (m_seen) begin
                    m_pending = 1'b0;
                    m_seen    = 1'b0;
                end
            end
        end

        if (m_fwd) busy = $urandom_range(1, 5);
        else if (busy > 0) busy--;
    endtask

    // Monitor: compares presented outputs against queued expectations.
    initial begin
        status_t s;
        cmd_t    c;
        forever begin
            @(negedge clk);
            if (status_q.size() > 0) begin
                s = status_q.pop_front();
                check("grant",        64'(grant),        64'(s.grant));
                check("req_ready",    64'(req_ready),    64'(s.ready));
                check("ddr3_request", 64'(ddr3_request), 64'(s.request));
                check("ddr3_strobe",  64'(ddr3_rd | ddr3_wr), 64'(s.strobe));
                check("ddr3_addr",    64'(ddr3_addr),    64'(s.addr));
                check("ddr3_din",     64'(ddr3_din),     64'(s.din));
                if (ddr3_rd || ddr3_wr) begin
                    if (cmd_q.size() == 0) begin
                        check("cmd_unexpected", 64'({ddr3_rd, ddr3_wr}), 64'(0));
                    end else begin
                        c = cmd_q.pop_front();
                        check("cmd_rd",   64'(ddr3_rd),   64'(c.rd));
                        check("cmd_wr",   64'(ddr3_wr),   64'(c.wr));
                        check("cmd_addr", 64'(ddr3_addr), 64'(c.addr));
                        check("cmd_din",  64'(ddr3_din),  64'(c.din));
                    end
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_rd     = '0;
        req_wr     = '0;
        req_addr   = '0;
        req_din    = '0;
        ddr3_ready = 1'b1;
        m_owner    = -1;
        m_last     = N - 1;
        m_pending  = 1'b0;
        m_seen     = 1'b0;
        m_hold     = 0;
        m_fwd      = 1'b0;
        busy       = 0;
        for (int i = 0; i < N; i++) burst_left[i] = 0;

        repeat (3) @(posedge clk);
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            #1;
            cyc_now = cyc;
            drive_cycle(cyc);
            model_cycle();
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        check("status_q_drain", 64'(status_q.size()), 64'(0));
        check("cmd_q_drain",    64'(cmd_q.size()),    64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
